// File: rtl/requant_gain_table_if.sv
// Bus bundle between the requantizer / control-register side and the gain table.
// The requantizer drives ce/sync_in/addr and consumes gain.
// Software drives the write/commit/fill controls and reads back the status flags.
// Handshake: there is no ready/valid pairing. Every request (wr_en, commit, fill_start) is a
// one-cycle strobe sampled on the rising clock edge. A request that arrives while busy or
// pending is high is dropped and latched into the sticky wr_drop flag.
interface requant_gain_table_if #(
  parameter int AW         = 11,
  parameter int GAIN_WIDTH = 11,
  parameter int CNT_WIDTH  = 16
);
  logic                  ce;
  logic                  sync_in;
  logic [AW-1:0]         addr;
  logic [GAIN_WIDTH-1:0] gain;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [GAIN_WIDTH-1:0] wr_data;
  logic                  commit;
  logic                  fill_start;
  logic [GAIN_WIDTH-1:0] fill_value;
  logic                  busy;
  logic                  pending;
  logic                  active_bank;
  logic                  wr_drop;
  logic [CNT_WIDTH-1:0]  swap_cnt;

  modport slave (
    input  ce, sync_in, addr, wr_en, wr_addr, wr_data, commit, fill_start, fill_value,
    output gain, busy, pending, active_bank, wr_drop, swap_cnt
  );

  modport master (
    output ce, sync_in, addr, wr_en, wr_addr, wr_data, commit, fill_start, fill_value,
    input  gain, busy, pending, active_bank, wr_drop, swap_cnt
  );
endinterface

// File: rtl/requant_gain_table.sv
// Double-buffered per-channel gain table for the requantizer.
// The active bank answers addr combinationally in the same cycle.
// Software writes or fills the shadow bank, then issues commit.
// The banks swap only on the next qualified spectrum boundary (sync_in with ce), so a single
// spectrum never sees a mix of old and new gains.
module requant_gain_table #(
  parameter int CHANNELS     = 2048,
  parameter int GAIN_WIDTH   = 11,
  parameter int DEFAULT_GAIN = 1,
  parameter int CNT_WIDTH    = 16,
  localparam int AW          = $clog2(CHANNELS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  requant_gain_table_if.slave    bus,
  output logic [1:0]             fsm_state
);

  localparam logic [GAIN_WIDTH-1:0] DEF_GAIN = GAIN_WIDTH'(DEFAULT_GAIN);
  localparam logic [AW-1:0]         LAST_CH  = AW'(CHANNELS - 1);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_FILL = 2'd2
  } state_t;

  state_t                state;
  logic [AW-1:0]         fill_cnt;
  logic [GAIN_WIDTH-1:0] fill_val;
  logic                  active_bank;
  logic                  pending;
  logic                  wr_drop;
  logic [CNT_WIDTH-1:0]  swap_cnt;

  // Storage is plain distributed RAM: it has no reset, because INIT rewrites every entry anyway.
  logic [GAIN_WIDTH-1:0] bank0 [CHANNELS];
  logic [GAIN_WIDTH-1:0] bank1 [CHANNELS];

  logic                  busy;
  logic                  rejected;
  logic                  req_any;
  logic                  wr_ok;
  logic                  fill_ok;
  logic                  commit_ok;
  logic                  swap_now;
  logic                  read_bank;
  logic                  we0;
  logic                  we1;
  logic [AW-1:0]         waddr;
  logic [GAIN_WIDTH-1:0] wdata;
  logic [GAIN_WIDTH-1:0] rd0;
  logic [GAIN_WIDTH-1:0] rd1;

  // Request qualification.
  // A request is refused while the table is initialising or filling, and also while a swap
  // is still outstanding, so the shadow bank cannot change under a pending commit.
  always_comb begin
    busy      = (state != S_IDLE);
    rejected  = busy | pending;
    req_any   = bus.wr_en | bus.fill_start | bus.commit;
    wr_ok     = bus.wr_en & ~rejected;
    fill_ok   = bus.fill_start & ~rejected;
    commit_ok = bus.commit & ~rejected;
    swap_now  = pending & bus.ce & bus.sync_in;
    // The sync cycle (addr wrapped to 0) already reads the incoming bank.
    read_bank = active_bank ^ swap_now;
  end

  // Write-port steering: INIT writes both banks; IDLE writes and FILL write only the shadow bank.
  always_comb begin
    we0   = 1'b0;
    we1   = 1'b0;
    waddr = bus.wr_addr;
    wdata = bus.wr_data;
    case (state)
      S_INIT: begin
        we0   = 1'b1;
        we1   = 1'b1;
        waddr = fill_cnt;
        wdata = DEF_GAIN;
      end
      S_FILL: begin
        we0   = active_bank;
        we1   = ~active_bank;
        waddr = fill_cnt;
        wdata = fill_val;
      end
      S_IDLE: begin
        if (wr_ok) begin
          we0 = active_bank;
          we1 = ~active_bank;
        end
      end
      default: begin
        we0 = 1'b0;
        we1 = 1'b0;
      end
    endcase
  end

  // Bank 0 synchronous write port.
  always_ff @(posedge clk) begin
    if (we0) bank0[waddr] <= wdata;
  end

  // Bank 1 synchronous write port.
  always_ff @(posedge clk) begin
    if (we1) bank1[waddr] <= wdata;
  end

  // Zero-latency read. Entries are not yet valid during INIT, so the default gain is forced.
  always_comb begin
    rd0      = bank0[bus.addr];
    rd1      = bank1[bus.addr];
    bus.gain = (state == S_INIT) ? DEF_GAIN : (read_bank ? rd1 : rd0);
  end

  // Sequencer for INIT and FILL. It runs every cycle and ignores ce, because software timing is
  // independent of the requantizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_INIT;
      fill_cnt <= '0;
      fill_val <= '0;
    end else begin
      case (state)
        S_INIT: begin
          fill_cnt <= fill_cnt + AW'(1);
          if (fill_cnt == LAST_CH) begin
            state    <= S_IDLE;
            fill_cnt <= '0;
          end
        end
        S_IDLE: begin
          if (fill_ok) begin
            state    <= S_FILL;
            fill_cnt <= '0;
            fill_val <= bus.fill_value;
          end
        end
        S_FILL: begin
          fill_cnt <= fill_cnt + AW'(1);
          if (fill_cnt == LAST_CH) begin
            state    <= S_IDLE;
            fill_cnt <= '0;
          end
        end
        default: begin
          state    <= S_INIT;
          fill_cnt <= '0;
        end
      endcase
    end
  end

  // Commit/swap bookkeeping and the sticky reject flag.
  // A commit only raises pending, so a sync in that same cycle cannot swap. Only a later sync
  // with pending already high qualifies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_bank <= 1'b0;
      pending     <= 1'b0;
      wr_drop     <= 1'b0;
      swap_cnt    <= '0;
    end else begin
      if (swap_now) begin
        active_bank <= ~active_bank;
        pending     <= 1'b0;
        swap_cnt    <= swap_cnt + CNT_WIDTH'(1);
      end else if (commit_ok) begin
        pending     <= 1'b1;
      end
      if (req_any && rejected) wr_drop <= 1'b1;
    end
  end

  assign bus.busy        = busy;
  assign bus.pending     = pending;
  assign bus.active_bank = active_bank;
  assign bus.wr_drop     = wr_drop;
  assign bus.swap_cnt    = swap_cnt;
  assign fsm_state       = state;

endmodule

// File: tb/tb_requant_gain_table.sv
// Bench for requant_gain_table: directed vector table, hand-written corner sequences and a
// randomized phase. Every cycle is also checked against a transaction-level model.
module tb_requant_gain_table;
  localparam int CH  = 2048;
  localparam int GW  = 11;
  localparam int CW  = 16;
  localparam int AW  = 11;
  localparam int DEF = 1;

  typedef struct {
    bit          ce;
    bit          sync_in;
    int          addr;
    bit          wr_en;
    int          wr_addr;
    int          wr_data;
    bit          commit;
    bit          fill_start;
    int          fill_value;
  } in_t;

  typedef struct {
    in_t in;
    int  exp_gain;
    int  exp_pend;
    int  exp_act;
    int  exp_drop;
    int  exp_cnt;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] fsm_state;

  requant_gain_table_if #(.AW(AW), .GAIN_WIDTH(GW), .CNT_WIDTH(CW)) bus ();

  requant_gain_table #(
    .CHANNELS(CH), .GAIN_WIDTH(GW), .DEFAULT_GAIN(DEF), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .fsm_state(fsm_state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: whole-table view of both banks.
  // A fill lands all at once; INIT is just a busy countdown, since its content is the default.
  int m_bank [2][CH];
  int m_act;
  int m_pend;
  int m_drop;
  int m_cnt;
  int m_busy_left;
  bit m_init;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic in_t mk(input bit ce, input bit sy, input int addr, input bit we,
                             input int wa, input int wd, input bit cm, input bit fs,
                             input int fv);
    in_t i;
    i.ce = ce; i.sync_in = sy; i.addr = addr; i.wr_en = we; i.wr_addr = wa; i.wr_data = wd;
    i.commit = cm; i.fill_start = fs; i.fill_value = fv;
    return i;
  endfunction

  function automatic in_t idle(input int addr);
    return mk(1, 0, addr, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t mv(input in_t i, input int g, input int p, input int a,
                              input int d, input int c);
    vec_t v;
    v.in = i; v.exp_gain = g; v.exp_pend = p; v.exp_act = a; v.exp_drop = d; v.exp_cnt = c;
    return v;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < CH; c++) m_bank[b][c] = DEF;
    m_act = 0; m_pend = 0; m_drop = 0; m_cnt = 0;
    m_busy_left = CH; m_init = 1;
  endtask

  // Compare all DUT outputs with the model for the current (pre-edge) cycle.
  task automatic model_check(input in_t i);
    int rb;
    int eg;
    rb = m_act ^ ((m_pend != 0 && i.ce && i.sync_in) ? 1 : 0);
    eg = m_init ? DEF : m_bank[rb][i.addr];
    check("model_gain", int'(bus.gain), eg);
    check("model_busy", int'(bus.busy), (m_busy_left > 0) ? 1 : 0);
    check("model_pending", int'(bus.pending), m_pend);
    check("model_active", int'(bus.active_bank), m_act);
    check("model_drop", int'(bus.wr_drop), m_drop);
    check("model_swap_cnt", int'(bus.swap_cnt), m_cnt % (1 << CW));
  endtask

  // Apply the effect of one clock edge to the model.
  task automatic model_edge(input in_t i);
    bit rej;
    bit swap;
    bit new_pend;
    rej      = (m_busy_left > 0) || (m_pend != 0);
    swap     = (m_pend != 0) && i.ce && i.sync_in;
    new_pend = 0;
    if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) m_init = 0;
    end
    if ((i.wr_en || i.fill_start || i.commit) && rej) begin
      m_drop = 1;
    end else begin
      if (i.wr_en) m_bank[1 - m_act][i.wr_addr] = i.wr_data;
      if (i.fill_start) begin
        for (int c = 0; c < CH; c++) m_bank[1 - m_act][c] = i.fill_value;
        m_busy_left = CH;
      end
      if (i.commit) new_pend = 1;
    end
    if (swap) begin
      m_act  = 1 - m_act;
      m_pend = 0;
      m_cnt++;
    end
    if (new_pend) m_pend = 1;
  endtask

  // Driver: set inputs, then compare on the falling edge.
  task automatic apply(input in_t i);
    bus.ce         = i.ce;
    bus.sync_in    = i.sync_in;
    bus.addr       = AW'(i.addr);
    bus.wr_en      = i.wr_en;
    bus.wr_addr    = AW'(i.wr_addr);
    bus.wr_data    = GW'(i.wr_data);
    bus.commit     = i.commit;
    bus.fill_start = i.fill_start;
    bus.fill_value = GW'(i.fill_value);
    @(negedge clk);
    model_check(i);
  endtask

  task automatic advance(input in_t i);
    @(posedge clk);
    model_edge(i);
    #1;
  endtask

  task automatic step(input in_t i);
    apply(i);
    advance(i);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply_raw_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(bus.busy), 1);
    check("rst_pending", int'(bus.pending), 0);
    check("rst_active", int'(bus.active_bank), 0);
    check("rst_drop", int'(bus.wr_drop), 0);
    check("rst_swap_cnt", int'(bus.swap_cnt), 0);
    check("rst_gain", int'(bus.gain), DEF);
    check("rst_state", int'(fsm_state), 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic apply_raw_idle();
    bus.ce = 1'b1; bus.sync_in = 1'b0; bus.addr = '0; bus.wr_en = 1'b0; bus.wr_addr = '0;
    bus.wr_data = '0; bus.commit = 1'b0; bus.fill_start = 1'b0; bus.fill_value = '0;
  endtask

  // Run idle cycles until busy drops. The count is returned, and a time-out is a failure.
  task automatic wait_idle(input string name, input int max, output int cycles);
    bit done;
    done   = 0;
    cycles = 0;
    for (int k = 0; k < max && !done; k++) begin
      apply(idle(k % CH));
      if (!bus.busy) done = 1;
      else cycles++;
      advance(idle(k % CH));
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: busy still high after %0d cycles", name, max);
    end
  endtask

  task automatic sweep(input string name, input int exp);
    for (int a = 0; a < CH; a++) begin
      apply(idle(a));
      check(name, int'(bus.gain), exp);
      advance(idle(a));
    end
  endtask

  vec_t tbl[12];

  initial begin
    int bc;
    in_t r;

    rst_n = 1'b0;
    apply_raw_idle();

    // Directed vectors, starting from a freshly initialised table (all gains 1, bank 0 active).
    tbl[0]  = mv(mk(1, 0, 5, 1, 5, 37, 0, 0, 0),  1, 0, 0, 0, 0);
    tbl[1]  = mv(mk(1, 0, 5, 0, 0, 0, 1, 0, 0),   1, 0, 0, 0, 0);
    tbl[2]  = mv(idle(5),                          1, 1, 0, 0, 0);
    tbl[3]  = mv(mk(0, 1, 5, 0, 0, 0, 0, 0, 0),   1, 1, 0, 0, 0);
    tbl[4]  = mv(idle(5),                          1, 1, 0, 0, 0);
    tbl[5]  = mv(mk(1, 1, 5, 0, 0, 0, 0, 0, 0),  37, 1, 0, 0, 0);
    tbl[6]  = mv(idle(5),                         37, 0, 1, 0, 1);
    tbl[7]  = mv(mk(1, 1, 5, 0, 0, 0, 1, 0, 0),  37, 0, 1, 0, 1);
    tbl[8]  = mv(mk(1, 0, 5, 1, 5, 99, 0, 0, 0), 37, 1, 1, 0, 1);
    tbl[9]  = mv(idle(5),                         37, 1, 1, 1, 1);
    tbl[10] = mv(mk(1, 1, 5, 0, 0, 0, 0, 0, 0),   1, 1, 1, 1, 1);
    tbl[11] = mv(idle(5),                          1, 0, 0, 1, 2);

    // Reset release: busy for exactly CH cycles, then unity gain everywhere.
    do_reset();
    wait_idle("init1_wait", CH + 16, bc);
    check("init1_busy_cycles", bc, CH);
    check("init1_state_idle", int'(fsm_state), 1);
    sweep("init1_gain", DEF);

    // Write/commit/swap vectors, including ce-gated sync and commit coinciding with sync.
    for (int k = 0; k < 12; k++) begin
      apply(tbl[k].in);
      check($sformatf("vec%0d_gain", k), int'(bus.gain), tbl[k].exp_gain);
      check($sformatf("vec%0d_pending", k), int'(bus.pending), tbl[k].exp_pend);
      check($sformatf("vec%0d_active", k), int'(bus.active_bank), tbl[k].exp_act);
      check($sformatf("vec%0d_drop", k), int'(bus.wr_drop), tbl[k].exp_drop);
      check($sformatf("vec%0d_swap_cnt", k), int'(bus.swap_cnt), tbl[k].exp_cnt);
      advance(tbl[k].in);
    end

    // Fill the shadow bank with 0x3FF. A write during FILL is dropped. Then commit, sync and sweep.
    do_reset();
    wait_idle("init2_wait", CH + 16, bc);
    step(mk(1, 0, 0, 0, 0, 0, 0, 1, 'h3FF));
    step(mk(1, 0, 0, 1, 7, 5, 0, 0, 0));
    apply(idle(0));
    check("fill_wr_drop", int'(bus.wr_drop), 1);
    check("fill_busy", int'(bus.busy), 1);
    check("fill_state", int'(fsm_state), 2);
    advance(idle(0));
    wait_idle("fill_wait", CH + 16, bc);
    check("fill_busy_cycles", bc, CH - 2);
    step(mk(1, 0, 0, 0, 0, 0, 1, 0, 0));
    step(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    check("fill_active", int'(bus.active_bank), 1);
    sweep("fill_gain", 'h3FF);

    // Reset in the middle of FILL while a commit is pending.
    step(mk(1, 0, 0, 0, 0, 0, 1, 1, 'h155));
    for (int k = 0; k < 100; k++) step(idle(k));
    apply(idle(0));
    check("midfill_pending", int'(bus.pending), 1);
    check("midfill_busy", int'(bus.busy), 1);
    advance(idle(0));
    do_reset();
    wait_idle("init3_wait", CH + 16, bc);
    check("init3_busy_cycles", bc, CH);
    sweep("init3_gain", DEF);

    // Randomized traffic on a small channel window, so that writes are read back.
    for (int k = 0; k < 4000; k++) begin
      r.ce         = ($urandom_range(0, 3) != 0);
      r.sync_in    = ($urandom_range(0, 15) == 0);
      r.addr       = $urandom_range(0, 15);
      r.wr_en      = ($urandom_range(0, 2) == 0);
      r.wr_addr    = $urandom_range(0, 15);
      r.wr_data    = $urandom_range(0, (1 << GW) - 1);
      r.commit     = ($urandom_range(0, 19) == 0);
      r.fill_start = !r.commit && ($urandom_range(0, 799) == 0);
      r.fill_value = $urandom_range(0, (1 << GW) - 1);
      step(r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
